// File: rtl/execute_cycle.sv
// Execute stage of the 5-stage RV32I pipeline: operand forwarding, ALU, beq resolution,
// branch target generation and the E/M pipeline register with stall and flush.
module execute_cycle #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Valid_E,
    input  logic              RegWrite_E,
    input  logic              ALUSrc_E,
    input  logic              MemWrite_E,
    input  logic              ResultSrc_E,
    input  logic              Branch_E,
    input  logic [2:0]        ALUControl_E,
    input  logic [XLEN-1:0]   RD1_E,
    input  logic [XLEN-1:0]   RD2_E,
    input  logic [XLEN-1:0]   Imm_Ext_E,
    input  logic [XLEN-1:0]   PC_E,
    input  logic [XLEN-1:0]   PCPlus4_E,
    input  logic [REG_AW-1:0] Rd_E,
    input  logic [1:0]        ForwardA_E,
    input  logic [1:0]        ForwardB_E,
    input  logic [XLEN-1:0]   Result_W,
    input  logic              Stall_M,
    input  logic              Flush_M,
    output logic              PCSrc_E,
    output logic [XLEN-1:0]   PCTarget_E,
    output logic              Valid_M,
    output logic              RegWrite_M,
    output logic              MemWrite_M,
    output logic              ResultSrc_M,
    output logic [REG_AW-1:0] Rd_M,
    output logic [XLEN-1:0]   ALUResult_M,
    output logic [XLEN-1:0]   WriteData_M,
    output logic [XLEN-1:0]   PCPlus4_M
);

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            zero;

    // FWD_MEM taps the E/M register itself, so a back-to-back dependency needs no stall.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        src_a = RD1_E;
        case (ForwardA_E)
            FWD_WB:  src_a = Result_W;
            FWD_MEM: src_a = ALUResult_M;
            default: src_a = RD1_E;
        endcase
    end

    always_comb begin
        fwd_b = RD2_E;
        case (ForwardB_E)
            FWD_WB:  fwd_b = Result_W;
            FWD_MEM: fwd_b = ALUResult_M;
            default: fwd_b = RD2_E;
        endcase
    end

    assign src_b = ALUSrc_E ? Imm_Ext_E : fwd_b;

    always_comb begin
        alu_result = '0;
        case (ALUControl_E)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_result = '0;
        endcase
    end

    assign zero       = (alu_result == '0);
    assign PCSrc_E    = Valid_E & Branch_E & zero;
    assign PCTarget_E = PC_E + Imm_Ext_E;

    // E/M register: reset > flush > stall > load. Store data is the forwarded RD2, not src_b.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (!rst) begin
            Valid_M     <= 1'b0;
            RegWrite_M  <= 1'b0;
            MemWrite_M  <= 1'b0;
            ResultSrc_M <= 1'b0;
            Rd_M        <= '0;
            ALUResult_M <= '0;
            WriteData_M <= '0;
            PCPlus4_M   <= '0;
        end else if (Flush_M) begin
            Valid_M     <= 1'b0;
            RegWrite_M  <= 1'b0;
            MemWrite_M  <= 1'b0;
            ResultSrc_M <= 1'b0;
            Rd_M        <= '0;
            ALUResult_M <= '0;
            WriteData_M <= '0;
            PCPlus4_M   <= '0;
        end else if (!Stall_M) begin
            Valid_M     <= Valid_E;
            RegWrite_M  <= RegWrite_E & Valid_E;
            MemWrite_M  <= MemWrite_E & Valid_E;
            ResultSrc_M <= ResultSrc_E;
            Rd_M        <= Rd_E;
            ALUResult_M <= alu_result;
            WriteData_M <= fwd_b;
            PCPlus4_M   <= PCPlus4_E;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// Directed bench for execute_cycle: stimulus pushes the expected E/M contents into a queue,
// a monitor pops and compares one entry after each rising edge.
module tb_execute_cycle;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        alusrc;
        logic        memwrite;
        logic        resultsrc;
        logic        branch;
        logic [2:0]  aluc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] result_w;
        logic        stall;
        logic        flush;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        memwrite;
        logic        resultsrc;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
    } m_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        Valid_E = 1'b0, RegWrite_E = 1'b0, ALUSrc_E = 1'b0, MemWrite_E = 1'b0;
    logic        ResultSrc_E = 1'b0, Branch_E = 1'b0;
    logic [2:0]  ALUControl_E = '0;
    logic [31:0] RD1_E = '0, RD2_E = '0, Imm_Ext_E = '0, PC_E = '0, PCPlus4_E = '0, Result_W = '0;
    logic [4:0]  Rd_E = '0;
    logic [1:0]  ForwardA_E = '0, ForwardB_E = '0;
    logic        Stall_M = 1'b0, Flush_M = 1'b0;
    logic        PCSrc_E;
    logic [31:0] PCTarget_E;
    logic        Valid_M, RegWrite_M, MemWrite_M, ResultSrc_M;
    logic [4:0]  Rd_M;
    logic [31:0] ALUResult_M, WriteData_M, PCPlus4_M;

    int total = 0;
    int bad   = 0;
    m_t exp_q[$];

    execute_cycle #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst),
        .Valid_E(Valid_E), .RegWrite_E(RegWrite_E), .ALUSrc_E(ALUSrc_E), .MemWrite_E(MemWrite_E),
        .ResultSrc_E(ResultSrc_E), .Branch_E(Branch_E), .ALUControl_E(ALUControl_E),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PC_E(PC_E), .PCPlus4_E(PCPlus4_E),
        .Rd_E(Rd_E), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .Result_W(Result_W),
        .Stall_M(Stall_M), .Flush_M(Flush_M),
        .PCSrc_E(PCSrc_E), .PCTarget_E(PCTarget_E),
        .Valid_M(Valid_M), .RegWrite_M(RegWrite_M), .MemWrite_M(MemWrite_M), .ResultSrc_M(ResultSrc_M),
        .Rd_M(Rd_M), .ALUResult_M(ALUResult_M), .WriteData_M(WriteData_M), .PCPlus4_M(PCPlus4_M)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic m_t actual();
        m_t a;
        a.valid = Valid_M; a.regwrite = RegWrite_M; a.memwrite = MemWrite_M; a.resultsrc = ResultSrc_M;
        a.rd = Rd_M; a.alu = ALUResult_M; a.wd = WriteData_M; a.pc4 = PCPlus4_M;
        return a;
    endfunction

    task automatic compare_m(input string tag, input m_t a, input m_t e);
        check({tag, ".Valid_M"},     32'(a.valid),     32'(e.valid));
        check({tag, ".RegWrite_M"},  32'(a.regwrite),  32'(e.regwrite));
        check({tag, ".MemWrite_M"},  32'(a.memwrite),  32'(e.memwrite));
        check({tag, ".ResultSrc_M"}, 32'(a.resultsrc), 32'(e.resultsrc));
        check({tag, ".Rd_M"},        32'(a.rd),        32'(e.rd));
        check({tag, ".ALUResult_M"}, a.alu,            e.alu);
        check({tag, ".WriteData_M"}, a.wd,             e.wd);
        check({tag, ".PCPlus4_M"},   a.pc4,            e.pc4);
    endtask

    function automatic in_t op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                               input logic src, input logic [31:0] imm, input logic [4:0] rd);
        in_t s = '0;
        s.valid = 1'b1; s.regwrite = 1'b1; s.aluc = c; s.rd1 = a; s.rd2 = b;
        s.alusrc = src; s.imm = imm; s.rd = rd; s.pc = 32'h40; s.pc4 = 32'h44;
        return s;
    endfunction

    function automatic m_t mres(input logic [31:0] alu, input logic [4:0] rd, input logic [31:0] wd);
        m_t e = '0;
        e.valid = 1'b1; e.regwrite = 1'b1; e.rd = rd; e.alu = alu; e.wd = wd; e.pc4 = 32'h44;
        return e;
    endfunction

    task automatic apply(input in_t s);
        Valid_E = s.valid; RegWrite_E = s.regwrite; ALUSrc_E = s.alusrc; MemWrite_E = s.memwrite;
        ResultSrc_E = s.resultsrc; Branch_E = s.branch; ALUControl_E = s.aluc;
        RD1_E = s.rd1; RD2_E = s.rd2; Imm_Ext_E = s.imm; PC_E = s.pc; PCPlus4_E = s.pc4;
        Rd_E = s.rd; ForwardA_E = s.fa; ForwardB_E = s.fb; Result_W = s.result_w;
        Stall_M = s.stall; Flush_M = s.flush;
    endtask

    // Drive one instruction on the falling edge and queue what the E/M register must hold after the next rise.
    task automatic step(input in_t s, input m_t e);
        @(negedge clk);
        apply(s);
        exp_q.push_back(e);
        #1;
    endtask

    initial begin : monitor
        m_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                compare_m("m", actual(), e);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        in_t s;
        m_t  e;
        m_t  held;

        // Reset held from time zero, and an add that loads on the first edge after release.
        #2;
        compare_m("reset", actual(), '0);
        rst = 1'b1;
        step(op(3'b000, 32'd5, 32'd0, 1'b1, 32'd7, 5'd3), mres(32'd12, 5'd3, 32'd0));

        // Mid-operation reset between edges clears M immediately and holds it.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        compare_m("async_reset", actual(), '0);
        @(posedge clk);
        #1;
        compare_m("reset_held", actual(), '0);
        rst = 1'b1;

        // ALU operations.
        step(op(3'b001, 32'd3, 32'd5, 1'b0, 32'd0, 5'd4), mres(32'hFFFFFFFE, 5'd4, 32'd5));
        step(op(3'b101, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, 5'd4), mres(32'd1, 5'd4, 32'd1));
        step(op(3'b101, 32'd1, 32'hFFFFFFFF, 1'b0, 32'd0, 5'd4), mres(32'd0, 5'd4, 32'hFFFFFFFF));
        step(op(3'b000, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, 5'd5), mres(32'd0, 5'd5, 32'd1));
        step(op(3'b010, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 32'd0, 5'd6), mres(32'h00F000F0, 5'd6, 32'h0FF00FF0));
        step(op(3'b011, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 32'd0, 5'd6), mres(32'hFFF0FFF0, 5'd6, 32'h0FF00FF0));
        step(op(3'b111, 32'd9, 32'd3, 1'b0, 32'd0, 5'd7), mres(32'd0, 5'd7, 32'd3));
        step(op(3'b100, 32'd9, 32'd3, 1'b0, 32'd0, 5'd7), mres(32'd0, 5'd7, 32'd3));

        // Forwarding: M-stage, W-stage, code 11, and store data from the forwarded RD2.
        step(op(3'b000, 32'd10, 32'd20, 1'b0, 32'd0, 5'd1), mres(32'd30, 5'd1, 32'd20));
        s = op(3'b000, 32'd0, 32'd0, 1'b1, 32'd1, 5'd2); s.fa = 2'b10;
        step(s, mres(32'd31, 5'd2, 32'd0));
        s = op(3'b000, 32'h100, 32'd0, 1'b1, 32'd4, 5'd7);
        s.fb = 2'b01; s.result_w = 32'h55; s.memwrite = 1'b1; s.regwrite = 1'b0;
        e = mres(32'h104, 5'd7, 32'h55); e.memwrite = 1'b1; e.regwrite = 1'b0;
        step(s, e);
        s = op(3'b000, 32'd0, 32'd0, 1'b1, 32'h10, 5'd8); s.fa = 2'b01; s.result_w = 32'h22; s.resultsrc = 1'b1;
        e = mres(32'h32, 5'd8, 32'd0); e.resultsrc = 1'b1;
        step(s, e);
        s = op(3'b000, 32'd7, 32'd0, 1'b1, 32'd0, 5'd9); s.fa = 2'b11; s.result_w = 32'd99;
        step(s, mres(32'd7, 5'd9, 32'd0));
        s = op(3'b000, 32'd1, 32'd0, 1'b0, 32'd0, 5'd10); s.fb = 2'b10;
        step(s, mres(32'd8, 5'd10, 32'd7));

        // Branches: taken, not taken, invalid slot, non-branch with zero result, target wrap.
        s = op(3'b001, 32'd9, 32'd9, 1'b0, 32'h20, 5'd0);
        s.regwrite = 1'b0; s.branch = 1'b1; s.pc = 32'h100; s.pc4 = 32'h104;
        e = mres(32'd0, 5'd0, 32'd9); e.regwrite = 1'b0; e.pc4 = 32'h104;
        step(s, e);
        check("beq_taken.PCSrc_E", 32'(PCSrc_E), 32'd1);
        check("beq_taken.PCTarget_E", PCTarget_E, 32'h120);
        s.rd2 = 32'd8;
        e.alu = 32'd1; e.wd = 32'd8;
        step(s, e);
        check("beq_not_taken.PCSrc_E", 32'(PCSrc_E), 32'd0);
        s.rd2 = 32'd9; s.valid = 1'b0; s.regwrite = 1'b1; s.memwrite = 1'b1;
        e.valid = 1'b0; e.regwrite = 1'b0; e.memwrite = 1'b0; e.alu = 32'd0; e.wd = 32'd9;
        step(s, e);
        check("beq_invalid.PCSrc_E", 32'(PCSrc_E), 32'd0);
        s = op(3'b001, 32'd9, 32'd9, 1'b0, 32'h20, 5'd11);
        step(s, mres(32'd0, 5'd11, 32'd9));
        check("no_branch_zero.PCSrc_E", 32'(PCSrc_E), 32'd0);
        s = op(3'b001, 32'd1, 32'd2, 1'b0, 32'h20, 5'd0);
        s.regwrite = 1'b0; s.branch = 1'b1; s.pc = 32'hFFFFFFF0;
        e = mres(32'hFFFFFFFF, 5'd0, 32'd2); e.regwrite = 1'b0;
        step(s, e);
        check("wrap.PCTarget_E", PCTarget_E, 32'h00000010);
        check("wrap.PCSrc_E", 32'(PCSrc_E), 32'd0);

        // Stall holds through changing inputs; flush wins over stall; release loads again.
        held = mres(32'd3, 5'd5, 32'd2);
        step(op(3'b000, 32'd1, 32'd2, 1'b0, 32'd0, 5'd5), held);
        s = op(3'b000, 32'd100, 32'd200, 1'b0, 32'd0, 5'd6); s.stall = 1'b1; s.memwrite = 1'b1;
        step(s, held);
        s = op(3'b011, 32'hAAAA, 32'h5555, 1'b0, 32'd0, 5'd12); s.stall = 1'b1; s.pc4 = 32'h88;
        step(s, held);
        s.flush = 1'b1;
        step(s, '0);
        step(op(3'b000, 32'd4, 32'd4, 1'b0, 32'd0, 5'd6), mres(32'd8, 5'd6, 32'd4));
        s = op(3'b000, 32'd4, 32'd4, 1'b0, 32'd0, 5'd6); s.flush = 1'b1; s.memwrite = 1'b1;
        step(s, '0);
        s.flush = 1'b0; s.stall = 1'b1;
        step(s, '0);
        s = '0;
        step(s, '0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        check("drain.queue_size", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
